// File: rtl/colour_conversion_controller.sv
// colour_conversion_controller
//   Sequencer for the YUV->RGB conversion datapath. For each word index it reads
//   one word from each of the Y, U and V planes. It then loads the matching
//   datapath registers. Next it steps the coefficient row (Smux2) through R, G
//   and B, and the pixel select (Smux1) through even then odd. Finally it writes
//   one packed pixel-pair word per output channel.
//   Every output is a decode of the registered state and index (Moore), so
//   start has no combinational path to any output.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      frame request, sampled only while idle
//   busy       high in every state except idle
//   done       one-cycle pulse after the last B write
//   mem_rd     read strobe; read data arrives one cycle later
//   mem_wr     write strobe; datapath drives the write data this cycle
//   mem_addr   address, zero when neither strobe is active
//   Yen_*/Uen_*/Ven_*  datapath register load enables
//   Smux1      1 = even pixel (low byte), 0 = odd pixel (high byte)
//   Smux2      coefficient row: 0 = R, 1 = G, 2 = B
//   Temp_en    capture the even-pixel result into the datapath Temp register
//   Cen        advance the datapath pixel counter, once per word
module colour_conversion_controller #(
  parameter int NUM_WORDS = 38400,
  parameter int ADDR_W    = 18,
  parameter int Y_BASE    = 0,
  parameter int U_BASE    = 38400,
  parameter int V_BASE    = 76800,
  parameter int OUT_BASE  = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              Yen_even,
  output logic              Yen_odd,
  output logic              Uen_even,
  output logic              Uen_odd,
  output logic              Ven_even,
  output logic              Ven_odd,
  output logic              Smux1,
  output logic [1:0]        Smux2,
  output logic              Temp_en,
  output logic              Cen
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RD_Y = 4'd1;
  localparam logic [3:0] S_RD_U = 4'd2;
  localparam logic [3:0] S_RD_V = 4'd3;
  localparam logic [3:0] S_LD_V = 4'd4;
  localparam logic [3:0] S_CE_R = 4'd5;
  localparam logic [3:0] S_CO_R = 4'd6;
  localparam logic [3:0] S_CE_G = 4'd7;
  localparam logic [3:0] S_CO_G = 4'd8;
  localparam logic [3:0] S_CE_B = 4'd9;
  localparam logic [3:0] S_CO_B = 4'd10;
  localparam logic [3:0] S_NEXT = 4'd11;
  localparam logic [3:0] S_DONE = 4'd12;

  // Plane base addresses reduced to ADDR_W bits so every address sum wraps
  // consistently in the memory address width.
  localparam logic [ADDR_W-1:0] Y_A      = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] U_A      = ADDR_W'(U_BASE);
  localparam logic [ADDR_W-1:0] V_A      = ADDR_W'(V_BASE);
  localparam logic [ADDR_W-1:0] R_A      = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] G_A      = ADDR_W'(OUT_BASE + NUM_WORDS);
  localparam logic [ADDR_W-1:0] B_A      = ADDR_W'(OUT_BASE + 2 * NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [ADDR_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        idx <= '0;
      end else if (state == S_NEXT && idx != LAST_IDX) begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RD_Y;
      S_RD_Y:  state_nxt = S_RD_U;
      S_RD_U:  state_nxt = S_RD_V;
      S_RD_V:  state_nxt = S_LD_V;
      S_LD_V:  state_nxt = S_CE_R;
      S_CE_R:  state_nxt = S_CO_R;
      S_CO_R:  state_nxt = S_CE_G;
      S_CE_G:  state_nxt = S_CO_G;
      S_CO_G:  state_nxt = S_CE_B;
      S_CE_B:  state_nxt = S_CO_B;
      S_CO_B:  state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (idx == LAST_IDX) ? S_DONE : S_RD_Y;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Each read's data lands one cycle later, so a plane's load enable is
  // asserted in the state after the one that issued its read.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    Yen_even = 1'b0;
    Yen_odd  = 1'b0;
    Uen_even = 1'b0;
    Uen_odd  = 1'b0;
    Ven_even = 1'b0;
    Ven_odd  = 1'b0;
    Smux1    = 1'b0;
    Smux2    = 2'd0;
    Temp_en  = 1'b0;
    Cen      = 1'b0;
    case (state)
      S_RD_Y: begin
        mem_rd   = 1'b1;
        mem_addr = Y_A + idx;
      end
      S_RD_U: begin
        mem_rd   = 1'b1;
        mem_addr = U_A + idx;
        Yen_even = 1'b1;
        Yen_odd  = 1'b1;
      end
      S_RD_V: begin
        mem_rd   = 1'b1;
        mem_addr = V_A + idx;
        Uen_even = 1'b1;
        Uen_odd  = 1'b1;
      end
      S_LD_V: begin
        Ven_even = 1'b1;
        Ven_odd  = 1'b1;
      end
      S_CE_R, S_CE_G, S_CE_B: begin
        Smux1   = 1'b1;
        Temp_en = 1'b1;
        Smux2   = (state == S_CE_R) ? 2'd0 : (state == S_CE_G) ? 2'd1 : 2'd2;
      end
      S_CO_R: begin
        mem_wr   = 1'b1;
        mem_addr = R_A + idx;
        Smux2    = 2'd0;
      end
      S_CO_G: begin
        mem_wr   = 1'b1;
        mem_addr = G_A + idx;
        Smux2    = 2'd1;
      end
      S_CO_B: begin
        mem_wr   = 1'b1;
        mem_addr = B_A + idx;
        Smux2    = 2'd2;
        Cen      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
